// File: rtl/tsbus_target.sv
// Responder on a shared tristate bus: decodes a one-word command, then either
// stores the following data word or drives the addressed register back after a turnaround.
module tsbus_target #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TURN  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] bus,
  input  logic             bus_valid,
  output logic             oe,
  output logic             busy,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (TURN > 1) ? $clog2(TURN) : 1;

  typedef enum logic [2:0] {IDLE, WDATA, TA1, DRIVE, TA2} state_t;

  state_t           state, stateNext;
  logic [CW-1:0]    cnt, cntNext;
  logic [AW-1:0]    addrQ;
  logic [WIDTH-1:0] rsp;
  logic [WIDTH-1:0] regs [DEPTH];

  logic             cmdWrite;
  logic [AW-1:0]    cmdAddr;
  logic             latchCmd, latchRsp, doWrite, setErr;

  assign cmdWrite = bus[WIDTH-1];
  assign cmdAddr  = bus[AW-1:0];

  // Gated combinationally so a misbehaving initiator can never cause contention.
  assign oe  = (state == DRIVE) && !bus_valid;
  assign bus = oe ? rsp : 'z;

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    latchCmd  = 1'b0;
    latchRsp  = 1'b0;
    doWrite   = 1'b0;
    setErr    = 1'b0;
    case (state)
      IDLE: begin
        if (bus_valid) begin
          latchCmd = 1'b1;
          cntNext  = '0;
          if (cmdWrite) begin
            stateNext = WDATA;
          end else begin
            latchRsp  = 1'b1;
            stateNext = TA1;
          end
        end
      end
      WDATA: begin
        if (bus_valid) doWrite = 1'b1;
        else           setErr  = 1'b1;
        stateNext = IDLE;
      end
      TA1: begin
        if (bus_valid) begin
          setErr    = 1'b1;
          cntNext   = '0;
          stateNext = IDLE;
        end else if (cnt == CW'(TURN - 1)) begin
          cntNext   = '0;
          stateNext = DRIVE;
        end else begin
          cntNext = cnt + CW'(1);
        end
      end
      DRIVE: begin
        if (bus_valid) begin
          setErr    = 1'b1;
          stateNext = IDLE;
        end else begin
          stateNext = TA2;
        end
        cntNext = '0;
      end
      TA2: begin
        if (bus_valid) begin
          setErr    = 1'b1;
          cntNext   = '0;
          stateNext = IDLE;
        end else if (cnt == CW'(TURN - 1)) begin
          cntNext   = '0;
          stateNext = IDLE;
        end else begin
          cntNext = cnt + CW'(1);
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
      addrQ <= '0;
      rsp   <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      busy  <= (stateNext != IDLE);
      if (setErr)   err   <= 1'b1;
      if (latchCmd) addrQ <= cmdAddr;
      if (latchRsp) rsp   <= regs[cmdAddr];
      if (doWrite)  regs[addrQ] <= bus;
    end
  end

endmodule

// File: tb/tb_tsbus_target.sv
// Randomized scoreboard bench for tsbus_target: a register-array model predicts
// each read response and the edge it must appear on; a monitor checks every drive cycle.
`timescale 1ns/1ps
module tb_tsbus_target;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int TURN  = 1;
  localparam int TURN3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, tbEn;
  logic [WIDTH-1:0] tbData;
  wire  [WIDTH-1:0] bus;
  logic             oe, busy, err;
  assign bus = tbEn ? tbData : 'z;

  logic             rst3_n, en3;
  logic [WIDTH-1:0] data3;
  wire  [WIDTH-1:0] bus3;
  logic             oe3, busy3, err3;
  assign bus3 = en3 ? data3 : 'z;

  tsbus_target #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TURN(TURN)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .bus_valid(tbEn),
    .oe(oe), .busy(busy), .err(err));

  tsbus_target #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TURN(TURN3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .bus(bus3), .bus_valid(en3),
    .oe(oe3), .busy(busy3), .err(err3));

  int checks = 0;
  int errors = 0;
  int edgeCnt = 0;
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               atEdge;
  } exp_t;
  exp_t expQ[$];

  logic [WIDTH-1:0] model [DEPTH];
  logic             errModel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the target drives must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (oe === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_drive: oe=1 at edge %0d with bus=0x%0h, expected no drive", edgeCnt, bus);
      end else begin
        e = expQ.pop_front();
        check("read_data", 32'(bus), 32'(e.data));
        check("drive_edge", edgeCnt, e.atEdge);
      end
    end
  end

  task automatic drive(input logic v, input logic [WIDTH-1:0] d);
    tbEn = v;
    tbData = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'($urandom));
  endtask

  task automatic wrTxn(input int addr, input logic [WIDTH-1:0] data, input logic [WIDTH-1:0] junk);
    drive(1'b1, 8'h80 | (junk & 8'h7C) | 8'(addr));
    check("busy_wr_cmd", 32'(busy), 32'd1);
    drive(1'b1, data);
    model[addr] = data;
    check("busy_wr_done", 32'(busy), 32'd0);
    check("err_wr", 32'(err), 32'(errModel));
  endtask

  task automatic rdTxn(input int addr, input logic [WIDTH-1:0] junk);
    int e0;
    drive(1'b1, (junk & 8'h7C) | 8'(addr));
    e0 = edgeCnt;
    expQ.push_back('{model[addr], e0 + TURN});
    check("busy_rd_cmd", 32'(busy), 32'd1);
    repeat (2 * TURN) drive(1'b0, 8'($urandom));
    check("busy_rd_tail", 32'(busy), 32'd1);
    drive(1'b0, 8'($urandom));
    check("busy_rd_done", 32'(busy), 32'd0);
    check("err_rd", 32'(err), 32'(errModel));
  endtask

  task automatic resetMain();
    rst_n = 1'b0;
    #1;
    check("oe_reset", 32'(oe), 32'd0);
    check("busy_reset", 32'(busy), 32'd0);
    check("err_reset", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    errModel = 1'b0;
  endtask

  task automatic drive3(input logic v, input logic [WIDTH-1:0] d);
    en3 = v;
    data3 = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, oeSeen, seenEdge;
    logic [WIDTH-1:0] seenData;

    rst_n = 1'b0;
    rst3_n = 1'b0;
    tbEn = 1'($urandom);
    tbData = 8'($urandom);
    en3 = 1'b0;
    data3 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("oe_after_reset", 32'(oe), 32'd0);
    check("busy_after_reset", 32'(busy), 32'd0);
    check("err_after_reset", 32'(err), 32'd0);
    tbEn = 1'b0;
    rst_n = 1'b1;
    rst3_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    errModel = 1'b0;
    idle(2);

    for (int a = 0; a < DEPTH; a++) rdTxn(a, 8'($urandom));

    // Directed write/read, then address bits taken from the low bits only.
    wrTxn(2, 8'hA5, 8'h00);
    rdTxn(2, 8'h00);
    wrTxn(3, 8'hFF, 8'h04);
    rdTxn(3, 8'h00);
    for (int a = 0; a < 3; a++) rdTxn(a, 8'($urandom));

    // Back-to-back writes with no gap.
    wrTxn(0, 8'h5C, 8'($urandom));
    wrTxn(1, 8'h81, 8'($urandom));
    rdTxn(0, 8'h00);
    rdTxn(1, 8'h00);

    // Collision during the drive cycle.
    drive(1'b1, 8'h02);
    drive(1'b0, 8'($urandom));
    tbEn = 1'b1;
    tbData = 8'($urandom);
    #1;
    check("oe_gated_collision", 32'(oe), 32'd0);
    @(posedge clk);
    #1;
    errModel = 1'b1;
    check("err_collision", 32'(err), 32'd1);
    check("busy_collision", 32'(busy), 32'd0);
    wrTxn(1, 8'h3E, 8'h00);
    rdTxn(1, 8'h00);

    // Aborted write leaves the register untouched.
    resetMain();
    idle(1);
    wrTxn(1, 8'h3C, 8'h00);
    drive(1'b1, 8'h81);
    drive(1'b0, 8'($urandom));
    errModel = 1'b1;
    check("err_abort", 32'(err), 32'd1);
    check("busy_abort", 32'(busy), 32'd0);
    rdTxn(1, 8'h00);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(1, 0) == 1) wrTxn(int'($urandom_range(DEPTH - 1, 0)), 8'($urandom), 8'($urandom));
      else                           rdTxn(int'($urandom_range(DEPTH - 1, 0)), 8'($urandom));
      idle(int'($urandom_range(2, 0)));
    end

    // Reset in the middle of a TURN=3 read: no drive cycle may follow.
    drive3(1'b1, 8'h81);
    drive3(1'b1, 8'h5A);
    drive3(1'b1, 8'h01);
    check("busy3_cmd", 32'(busy3), 32'd1);
    drive3(1'b0, 8'h00);
    #2;
    rst3_n = 1'b0;
    #1;
    check("busy3_async_reset", 32'(busy3), 32'd0);
    check("oe3_async_reset", 32'(oe3), 32'd0);
    oeSeen = 0;
    repeat (2) begin
      @(negedge clk);
      if (oe3 === 1'b1) oeSeen++;
    end
    rst3_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (oe3 === 1'b1) oeSeen++;
    end
    check("no_drive_after_reset", oeSeen, 0);

    // Register cleared by that reset; response appears TURN edges after the command.
    @(posedge clk);
    #1;
    drive3(1'b1, 8'h01);
    e0 = edgeCnt;
    en3 = 1'b0;
    seenEdge = -1;
    seenData = 'x;
    repeat (10) begin
      @(negedge clk);
      if (oe3 === 1'b1 && seenEdge < 0) begin
        seenEdge = edgeCnt;
        seenData = bus3;
      end
    end
    check("t3_drive_edge", seenEdge, e0 + TURN3);
    check("t3_read_data", 32'(seenData), 32'd0);
    check("t3_busy_done", 32'(busy3), 32'd0);
    check("t3_err", 32'(err3), 32'd0);

    idle(6);
    check("scoreboard_empty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tsbus_target.md
# tsbus_target

Responder end of the shared tristate data bus: listens while the initiator drives the bus, decodes a one-word command, and either stores a following data word into a small register file or drives the addressed register back onto the same wires after a turnaround gap. Sits on the chip-side end of the bidirectional pad ring, opposite the initiator that owns `en`, and never drives the bus while the initiator does.

## Interface
- `WIDTH`, 8: bus width in bits; must be at least `AW+1`.
- `DEPTH`, 4: number of storage registers; must be a power of two, at least 2. `AW = log2(DEPTH)`.
- `TURN`, 1: idle (Z) cycles before and after a read response; must be at least 1.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `bus`  inout  WIDTH  shared tristate data bus.
- `bus_valid`  input  1  high while the initiator drives `bus` (initiator's `en`).
- `oe`  output  1  high while this block drives `bus`.
- `busy`  output  1  high whenever the state is not IDLE.
- `err`  output  1  sticky protocol-error flag; cleared only by reset.

## Operation
- Command word in IDLE: `bus[WIDTH-1]` is 1 for write, 0 for read. `bus[AW-1:0]` is the address. Other bits are ignored.
- States:
  - IDLE → WDATA on `bus_valid`=1 with a write command.
  - IDLE → TA1 on `bus_valid`=1 with a read command. The register value is latched into the response register at this edge.
  - WDATA with `bus_valid`=1: `bus` is written to `reg[addr]`, then IDLE.
  - WDATA with `bus_valid`=0: write aborted, no register changes, `err` set, then IDLE.
  - TA1 counts `TURN` cycles, then DRIVE.
  - DRIVE lasts one cycle, then TA2.
  - TA2 counts `TURN` cycles, then IDLE.
- Bus drive: `bus` = response register when `oe`=1, otherwise all Z.
  - `oe` = (state==DRIVE) & ~`bus_valid`.
  - The `bus_valid` gating is combinational, so contention is impossible even for a misbehaving initiator.
- Collision: `bus_valid`=1 during TA1, DRIVE or TA2:
  - `err` set at that edge and state goes to IDLE.
  - The command on `bus` in that cycle is not decoded.
- Register file: `DEPTH` × `WIDTH` flops, all reset to 0. Readback returns the full `WIDTH` bits.
- Reset mid-operation: state IDLE, `oe`=0 immediately (asynchronous), `bus`=Z, registers 0, `err`=0, counters 0.

## Timing
- Reset values: `oe`=0, `busy`=0, `err`=0, `bus`=Z.
- Write: command sampled at edge E0, data at E1. A read of the same address issued at E2 returns the new value.
- Read: command at E0, `busy`=1 from E0.
  - `bus` is Z for cycles E0..E0+TURN.
  - `oe`=1 and `bus` is valid from E0+TURN to E0+TURN+1; the initiator samples at E0+TURN+1.
  - `bus` is Z again for `TURN` cycles; `busy` falls at E0+2·TURN+1.
  - Next command is accepted at E0+2·TURN+1 or later.
- Back-to-back writes: command, data, command, data on consecutive edges, no gap required.
- `err` rises at the edge the violation is sampled and stays high.
- `busy` and `err` are registered. `oe` is registered state gated combinationally by `bus_valid`.

## Test plan
- Reset: `rst_n`=0 with all inputs random → `oe`=0, `bus`=Z, `busy`=0, `err`=0. Read of each address returns 0x00.
- Write/read, WIDTH=8, TURN=1:
  - Write cmd 0x82, then data 0xA5; then read cmd 0x02.
  - → `oe`=1 exactly on the 2nd cycle after the read command edge, with `bus`=0xA5.
  - → `bus` Z before and after that cycle; `busy` low 4 edges after the command.
- Address wrap: write 0xFF with cmd 0x87 (address bits = 3) → read cmd 0x03 returns 0xFF; other addresses unchanged.
- Collision: read cmd, then `bus_valid`=1 during the DRIVE cycle.
  - → `oe`=0 in that same cycle (no contention), `err`=1 at the next edge, state IDLE.
  - → A following write/read pair works normally; `err` stays 1.
- Aborted write: cmd 0x81, then `bus_valid`=0 → `err`=1 and reg[1] unchanged.
- Reset mid-read: assert `rst_n`=0 during TA1 with TURN=3 → `busy`=0 immediately and no drive cycle ever occurs.
